// File: rtl/sync_fifo_if.sv
// Byte-stream handshake bundle between a FIFO producer/consumer (master)
// and the FIFO itself (slave).
//   wr, rd     : write / read request strobes, sampled at posedge clk
//   data_in    : write data, captured when a write is accepted
//   data_out   : registered read data
//   full/empty : occupancy flags
interface sync_fifo_if #(
    parameter int unsigned DATA_WIDTH = 8
);
    logic                  wr;
    logic                  rd;
    logic [DATA_WIDTH-1:0] data_in;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  full;
    logic                  empty;

    modport master (
        output wr,
        output rd,
        output data_in,
        input  data_out,
        input  full,
        input  empty
    );

    modport slave (
        input  wr,
        input  rd,
        input  data_in,
        output data_out,
        output full,
        output empty
    );
endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO: DEPTH entries of DATA_WIDTH bits.
//   clk   : rising-edge clock for all state
//   reset : asynchronous active-low reset (clears pointers, count, data_out)
//   bus   : sync_fifo_if.slave - wr/rd/data_in in, data_out/full/empty out
// full/empty are registered copies of the next-count decode, so they only
// change on a clock edge or reset and never glitch with wr/rd/data_in.
module sync_fifo #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned DEPTH      = 8,
    parameter int unsigned ADDR_WIDTH = 3
) (
    input  logic         clk,
    input  logic         reset,
    sync_fifo_if.slave   bus
);
    localparam int unsigned CNT_W = ADDR_WIDTH + 1;

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [ADDR_WIDTH-1:0] r_wp;
    logic [ADDR_WIDTH-1:0] r_rp;
    logic [CNT_W-1:0]      r_cnt;
    logic [DATA_WIDTH-1:0] r_data_out;
    logic                  r_full;
    logic                  r_empty;

    logic                  w_rd_ok;
    logic                  w_wr_ok;
    logic [CNT_W-1:0]      w_cnt_nxt;

    // A write into a full FIFO is allowed only when a read frees a slot on the same edge.
    assign w_rd_ok = bus.rd && !r_empty;
    assign w_wr_ok = bus.wr && (!r_full || w_rd_ok);

    // Next occupancy.
    always_comb begin
        w_cnt_nxt = r_cnt;
        case ({w_wr_ok, w_rd_ok})
            2'b10:   w_cnt_nxt = r_cnt + CNT_W'(1);
            2'b01:   w_cnt_nxt = r_cnt - CNT_W'(1);
            default: w_cnt_nxt = r_cnt;
        endcase
    end

    // Storage is intentionally not reset.
    always_ff @(posedge clk) begin
        if (w_wr_ok) begin
            r_mem[r_wp] <= bus.data_in;
        end
    end

    // Pointers, count, flags and read data.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wp       <= '0;
            r_rp       <= '0;
            r_cnt      <= '0;
            r_data_out <= '0;
            r_full     <= 1'b0;
            r_empty    <= 1'b1;
        end else begin
            if (w_wr_ok) begin
                r_wp <= r_wp + ADDR_WIDTH'(1);
            end
            if (w_rd_ok) begin
                r_rp       <= r_rp + ADDR_WIDTH'(1);
                r_data_out <= r_mem[r_rp];
            end
            r_cnt   <= w_cnt_nxt;
            r_full  <= (w_cnt_nxt == CNT_W'(DEPTH));
            r_empty <= (w_cnt_nxt == '0);
        end
    end

    assign bus.data_out = r_data_out;
    assign bus.full     = r_full;
    assign bus.empty    = r_empty;
endmodule

// File: tb/tb_sync_fifo.sv
// Self-checking bench for sync_fifo: directed scenarios plus random traffic,
// compared every cycle against a queue-based reference model.
module tb_sync_fifo;
    localparam int unsigned DW    = 8;
    localparam int unsigned DEPTH = 8;

    logic clk;
    logic reset;

    sync_fifo_if #(.DATA_WIDTH(DW)) bus ();

    sync_fifo #(
        .DATA_WIDTH(DW),
        .DEPTH     (DEPTH),
        .ADDR_WIDTH(3)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned    checks   = 0;
    int unsigned    failures = 0;
    logic [DW-1:0]  model_q[$];
    logic [DW-1:0]  model_dout = '0;

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".data_out"}, bus.data_out, model_dout);
        check({tag, ".full"},  DW'(bus.full),  DW'(model_q.size() == DEPTH));
        check({tag, ".empty"}, DW'(bus.empty), DW'(model_q.size() == 0));
    endtask

    // One clock: drive at negedge, apply FIFO rules to the model, check after the edge.
    task automatic cycle(input string tag, input logic w, input logic r, input logic [DW-1:0] d);
        bit rd_ok;
        bit wr_ok;
        @(negedge clk);
        bus.wr      = w;
        bus.rd      = r;
        bus.data_in = d;
        @(posedge clk);
        rd_ok = r && (model_q.size() != 0);
        wr_ok = w && ((model_q.size() < DEPTH) || rd_ok);
        if (rd_ok) model_dout = model_q.pop_front();
        if (wr_ok) model_q.push_back(d);
        #1;
        check_all(tag);
    endtask

    initial begin
        logic [DW-1:0] fill_vals [7];
        fill_vals = '{8'd100, 8'd150, 8'd200, 8'd40, 8'd70, 8'd65, 8'd15};

        reset       = 1'b0;
        bus.wr      = 1'b0;
        bus.rd      = 1'b0;
        bus.data_in = '0;
        @(posedge clk);
        #1;
        check_all("reset");
        @(negedge clk);
        reset = 1'b1;

        // Reads from empty after reset change nothing.
        for (int i = 0; i < 3; i++) cycle("rd_after_reset", 1'b0, 1'b1, 8'hAA);

        // Fill order.
        for (int i = 0; i < 7; i++) cycle("fill_wr", 1'b1, 1'b0, fill_vals[i]);
        for (int i = 0; i < 7; i++) begin
            cycle("fill_rd", 1'b0, 1'b1, 8'h00);
            check("fill_order", bus.data_out, fill_vals[i]);
        end

        // Overflow: 9th write dropped.
        for (int i = 1; i <= 8; i++) cycle("ovf_wr", 1'b1, 1'b0, DW'(i));
        cycle("ovf_drop", 1'b1, 1'b0, 8'd99);
        for (int i = 1; i <= 8; i++) begin
            cycle("ovf_rd", 1'b0, 1'b1, 8'h00);
            check("ovf_order", bus.data_out, DW'(i));
        end

        // Underflow: data_out holds 8.
        for (int i = 0; i < 3; i++) begin
            cycle("udf_rd", 1'b0, 1'b1, 8'h00);
            check("udf_hold", bus.data_out, 8'd8);
        end
        cycle("udf_wr", 1'b1, 1'b0, 8'd5);
        cycle("udf_rd5", 1'b0, 1'b1, 8'h00);
        check("udf_value5", bus.data_out, 8'd5);

        // Simultaneous from empty: only the write happens.
        cycle("sim_empty", 1'b1, 1'b1, 8'd7);
        check("sim_empty_hold", bus.data_out, 8'd5);
        cycle("sim_empty_rd", 1'b0, 1'b1, 8'h00);
        check("sim_empty_val", bus.data_out, 8'd7);

        // Simultaneous at full: oldest out, 9 stored, stays full.
        for (int i = 0; i < 8; i++) cycle("sim_fill", 1'b1, 1'b0, DW'(8'd20 + 8'(i)));
        cycle("sim_full", 1'b1, 1'b1, 8'd9);
        check("sim_full_oldest", bus.data_out, 8'd20);
        check("sim_full_flag", DW'(bus.full), 8'd1);
        for (int i = 0; i < 8; i++) cycle("sim_drain", 1'b0, 1'b1, 8'h00);
        check("sim_drain_last", bus.data_out, 8'd9);

        // Wrap: 20 write/read pairs.
        for (int i = 0; i < 20; i++) begin
            cycle("wrap_wr", 1'b1, 1'b0, DW'(8'd200 - 8'(i)));
            cycle("wrap_rd", 1'b0, 1'b1, 8'h00);
        end

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            cycle("rand", 1'($urandom_range(0, 99) < 55), 1'($urandom_range(0, 99) < 45),
                  DW'($urandom));
        end

        // Async reset mid-operation with entries stored.
        while (model_q.size() != 0) cycle("pre_rst_drain", 1'b0, 1'b1, 8'h00);
        for (int i = 0; i < 3; i++) cycle("pre_rst_wr", 1'b1, 1'b0, DW'(8'd31 + 8'(i)));
        cycle("pre_rst_rd", 1'b0, 1'b1, 8'h00);
        cycle("pre_rst_wr2", 1'b1, 1'b0, 8'd77);
        @(negedge clk);
        bus.wr = 1'b0;
        bus.rd = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        model_q.delete();
        model_dout = '0;
        check_all("async_reset");
        @(posedge clk);
        #1;
        check_all("reset_held");
        @(negedge clk);
        reset = 1'b1;
        cycle("post_rst_rd", 1'b0, 1'b1, 8'h00);
        check("post_rst_dout", bus.data_out, 8'd0);
        cycle("post_rst_wr", 1'b1, 1'b0, 8'd42);
        cycle("post_rst_rd42", 1'b0, 1'b1, 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/sync_fifo.md
Name: sync_fifo

Overview:
- Single-clock, synchronous first-in/first-out buffer: 8 entries of 8 bits by default.
- Decouples a byte producer from a byte consumer within one clock domain.
- Writes and reads are qualified by `wr`/`rd` strobes sampled on the rising clock edge.
- `full` and `empty` status flags provide flow control to both sides.

Parameters:
- DATA_WIDTH, 8, width of each stored word and of data_in/data_out.
- DEPTH, 8, number of storage entries; must be a power of two, at least 2.
- ADDR_WIDTH, 3, pointer width; equals log2(DEPTH).

Ports:
- clk  input  1  rising-edge clock for all state.
- reset  input  1  asynchronous, active-low reset; 0 clears state immediately.
- wr  input  1  write request, sampled at posedge clk.
- rd  input  1  read request, sampled at posedge clk.
- data_in  input  DATA_WIDTH  write data, captured when a write is accepted.
- data_out  output  DATA_WIDTH  registered read data.
- full  output  1  high when the FIFO holds DEPTH entries.
- empty  output  1  high when the FIFO holds 0 entries.

Behaviour:

State:
- Write pointer wp and read pointer rp, each ADDR_WIDTH bits.
- Occupancy count cnt, ADDR_WIDTH+1 bits, range 0..DEPTH.
- Storage array mem[DEPTH].
- data_out register.

Reset (reset=0, asynchronous assert, released synchronously to logic by the next clk edge):
- wp=0, rp=0, cnt=0.
- data_out=0, empty=1, full=0.
- mem contents are not cleared and do not need a defined value.

Flags:
- Combinational decode of the registered count: full=(cnt==DEPTH), empty=(cnt==0).
- Flags change only after a clock edge or a reset; they never glitch on wr, rd or data_in.

Write accepted when wr=1 and (full=0, or rd=1 with the read also accepted):
- mem[wp] <= data_in.
- wp <= wp+1, wrapping modulo DEPTH.

Read accepted when rd=1 and empty=0:
- data_out <= mem[rp].
- rp <= rp+1, wrapping modulo DEPTH.
- Latency: the word is visible on data_out one edge after the read request is sampled.

Count update:
- Write only: cnt +1.
- Read only: cnt -1.
- Both accepted, or neither: cnt unchanged.

Boundary conditions:
- wr=1 while full and rd=0: write ignored, no state change, data_in dropped.
- rd=1 while empty: read ignored, data_out holds its previous value, no pointer change.
- wr=1 and rd=1 while empty: only the write occurs; cnt 0->1, data_out unchanged.
- wr=1 and rd=1 while full: both occur; the oldest word goes to data_out, the new word is stored in the freed slot, full stays 1.
- wr=1 and rd=1 at intermediate occupancy: both occur, cnt unchanged.
- data_out holds its value whenever no read is accepted, including after wr/rd deassert.
- Pointer wrap-around is transparent: ordering is preserved across any number of wraps.
- Reset mid-operation: all stored data is discarded, the outputs go to their reset values immediately, and the FIFO behaves empty afterwards.
- wr/rd equal to X: not supported; the bench must drive 0/1 after reset.

Test Plan:
- Reset: hold reset=0 for one cycle, then release -> empty=1, full=0, data_out=0; rd=1 pulses change nothing.
- Fill order: write 100,150,200,40,70,65,15 on consecutive edges -> empty=0 after the first edge, full=0 after seven writes. Then rd=1 for 7 cycles -> data_out=100,150,200,40,70,65,15, each one edge after its read; empty=1 after the seventh read.
- Overflow: write 8 words 1..8 -> full=1. A 9th write of 99 is ignored. Reading 8 words returns 1..8, and 99 never appears.
- Underflow: from empty, rd=1 for 3 cycles after the last read returned 8 -> data_out stays 8, pointers do not move. A following write/read of 5 returns 5.
- Simultaneous access:
  - From empty, wr=1 rd=1 with data 7 -> cnt=1, data_out unchanged.
  - At full, wr=1 rd=1 with data 9 -> oldest word out, full stays 1.
  - Draining afterwards ends with 9.
- Wrap and async reset: perform 20 write/read pairs across pointer wrap and check order. Then assert reset=0 between edges with 3 entries stored -> empty=1 and data_out=0 immediately. After release, the next read attempt is ignored.
